// File: rtl/display_scan.sv
// Six-digit HH MM SS 7-segment scanner with once-per-frame snapshot and alarm blink.
// Define DISPLAY_12H_EN for 12-hour hours with a PM dot on the hour-ones digit.
module display_scan #(
    parameter int TIME_WIDTH   = 18,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [TIME_WIDTH-1:0] time_data,
    input  logic                  am_pm_div,
    input  logic                  alerm_equal,
    output logic [7:0]            seg,
    output logic [5:0]            digit_sel,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [17:0]      snap_time;
    logic             snap_valid;
    logic             blink_phase;
    logic [FRM_W-1:0] frame_cnt;

`ifdef DISPLAY_12H_EN
    logic snap_pm;
`else
    logic unused_pm;
    assign unused_pm = am_pm_div;
`endif

    // Returns {dash, tens, ones}; dash is set for anything above 59.
    function automatic logic [8:0] split_field(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] o;
        t = v / 6'd10;
        o = v % 6'd10;
        split_field = {(v > 6'd59), t[3:0], o[3:0]};
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hBF;
        endcase
    endfunction

    // Scan counter, digit index, snapshot and blink state.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt    <= '0;
            digit_idx   <= 3'd5;
            snap_time   <= '0;
            snap_valid  <= 1'b0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
`ifdef DISPLAY_12H_EN
            snap_pm     <= 1'b0;
`endif
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (digit_idx == 3'd5) begin
                digit_idx  <= 3'd0;
                snap_time  <= time_data[17:0];
                snap_valid <= 1'b1;
`ifdef DISPLAY_12H_EN
                snap_pm    <= am_pm_div;
`endif
                // frame_cnt counts frames already shown in the current phase.
                if (!alerm_equal) begin
                    frame_cnt   <= '0;
                    blink_phase <= 1'b0;
                end else if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= FRM_W'(1);
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end else begin
                digit_idx <= digit_idx + 3'd1;
            end
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    logic [5:0] hour_raw;
    logic [5:0] hour_disp;
    logic       hour_over;
    logic [8:0] hour_f;
    logic [8:0] min_f;
    logic [8:0] sec_f;
    logic [4:0] cur;
    logic [7:0] cur_seg;

    always_comb begin
        hour_raw  = snap_time[17:12];
        hour_disp = hour_raw;
        hour_over = 1'b0;
`ifdef DISPLAY_12H_EN
        hour_over = (hour_raw > 6'd23);
        if (hour_raw == 6'd0)
            hour_disp = 6'd12;
        else if (hour_raw > 6'd12 && hour_raw <= 6'd23)
            hour_disp = hour_raw - 6'd12;
`endif
        hour_f = split_field(hour_disp);
        hour_f[8] = hour_f[8] | hour_over;
        min_f  = split_field(snap_time[11:6]);
        sec_f  = split_field(snap_time[5:0]);

        case (digit_idx)
            3'd0:    cur = {hour_f[8], hour_f[7:4]};
            3'd1:    cur = {hour_f[8], hour_f[3:0]};
            3'd2:    cur = {min_f[8],  min_f[7:4]};
            3'd3:    cur = {min_f[8],  min_f[3:0]};
            3'd4:    cur = {sec_f[8],  sec_f[7:4]};
            default: cur = {sec_f[8],  sec_f[3:0]};
        endcase

        cur_seg = cur[4] ? 8'hBF : glyph(cur[3:0]);
`ifdef DISPLAY_12H_EN
        if (digit_idx == 3'd1 && snap_pm)
            cur_seg[7] = 1'b0;
`endif
    end

    // Outputs lag the scan state by one cycle; blank until the first snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg         <= 8'hFF;
            digit_sel   <= 6'h3F;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_valid && (digit_idx == 3'd0) && (scan_cnt == '0);
            if (!snap_valid || blink_phase) begin
                seg       <= 8'hFF;
                digit_sel <= 6'h3F;
            end else begin
                seg       <= cur_seg;
                digit_sel <= ~(6'b100000 >> digit_idx);
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=4, BLINK_FRAMES=2; expectations
// follow DISPLAY_12H_EN when it is defined.
module tb_display_scan;

    logic        clock;
    logic        reset;
    logic [17:0] time_data;
    logic        am_pm_div;
    logic        alerm_equal;
    logic [7:0]  seg;
    logic [5:0]  digit_sel;
    logic        frame_start;

    int n_cmp;
    int n_bad;
    logic [13:0] exp_q[$];

    display_scan #(
        .TIME_WIDTH  (18),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .time_data  (time_data),
        .am_pm_div  (am_pm_div),
        .alerm_equal(alerm_equal),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    // Hand-computed frames, hour tens first.
`ifdef DISPLAY_12H_EN
    localparam logic [47:0] E_1345_PM = 48'hC0_79_99_92_C0_F8;
    localparam logic [47:0] E_1345_AM = 48'hC0_F9_99_92_C0_F8;
    localparam logic [47:0] E_ZERO    = 48'hF9_A4_C0_C0_C0_C0;
    localparam logic [47:0] E_MIN60   = 48'hF9_A4_BF_BF_C0_C0;
    localparam logic [47:0] E_H24     = 48'hBF_BF_92_90_92_90;
    localparam logic [47:0] E_H12_PM  = 48'hF9_24_C0_C0_C0_C0;
    localparam logic [47:0] E_H23     = 48'hF9_F9_C0_C0_C0_C0;
`else
    localparam logic [47:0] E_1345_PM = 48'hF9_B0_99_92_C0_F8;
    localparam logic [47:0] E_1345_AM = 48'hF9_B0_99_92_C0_F8;
    localparam logic [47:0] E_ZERO    = 48'hC0_C0_C0_C0_C0_C0;
    localparam logic [47:0] E_MIN60   = 48'hC0_C0_BF_BF_C0_C0;
    localparam logic [47:0] E_H24     = 48'hA4_99_92_90_92_90;
    localparam logic [47:0] E_H12_PM  = 48'hF9_A4_C0_C0_C0_C0;
    localparam logic [47:0] E_H23     = 48'hA4_B0_C0_C0_C0_C0;
`endif

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag, input logic fs_exp);
        check({tag, "_sel"}, 32'(digit_sel), 32'h3F);
        check({tag, "_seg"}, 32'(seg), 32'hFF);
        check({tag, "_fs"}, 32'(frame_start), 32'(fs_exp));
    endtask

    task automatic set_inputs(input logic [17:0] t, input logic pm, input logic al);
        time_data   = t;
        am_pm_div   = pm;
        alerm_equal = al;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("frame_timeout", 32'(frame_start), 32'h1);
    endtask

    // Checks one full frame from its frame_start cycle; optionally changes
    // time_data when the minute-tens digit comes up.
    task automatic check_frame(input string tag, input logic blank, input logic [47:0] segs,
                               input logic mid_en, input logic [17:0] mid_data);
        logic [5:0]  sel;
        logic [13:0] e;
        wait_frame();
        for (int d = 0; d < 6; d++) begin
            sel = blank ? 6'h3F : ~(6'b100000 >> d);
            exp_q.push_back({sel, blank ? 8'hFF : segs[47 - 8*d -: 8]});
        end
        for (int d = 0; d < 6; d++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (mid_en && d == 2 && c == 0) time_data = mid_data;
                check($sformatf("%s_d%0d_c%0d_sel", tag, d, c), 32'(digit_sel), 32'(e[13:8]));
                check($sformatf("%s_d%0d_c%0d_fs", tag, d, c), 32'(frame_start),
                      32'((d == 0 && c == 0) ? 1 : 0));
                if (c == 0) check($sformatf("%s_d%0d_seg", tag, d), 32'(seg), 32'(e[7:0]));
                tick();
            end
        end
    endtask

    // Applies a vector at a frame boundary, lets the current frame run out,
    // then checks the frame built from the new snapshot.
    task automatic run_vec(input string tag, input logic [17:0] t, input logic pm,
                           input logic [47:0] segs);
        wait_frame();
        set_inputs(t, pm, 1'b0);
        tick();
        check_frame(tag, 1'b0, segs, 1'b0, 18'h0);
    endtask

    task automatic reset_release_check(input string tag);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_blank($sformatf("%s_pre%0d", tag, k), 1'b0);
        end
        tick();
        check({tag, "_first_fs"}, 32'(frame_start), 32'h1);
        check({tag, "_first_sel"}, 32'(digit_sel), 32'h1F);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        set_inputs(18'h0DB47, 1'b1, 1'b0);
        tick();
        tick();
        check_blank("reset", 1'b0);

        reset_release_check("release");
        check_frame("v1345pm", 1'b0, E_1345_PM, 1'b0, 18'h0);

        run_vec("vzero", 18'h00000, 1'b0, E_ZERO);
        run_vec("vmin60", 18'h00F00, 1'b0, E_MIN60);
        run_vec("vh24", 18'h18EFB, 1'b0, E_H24);
        run_vec("vh12pm", 18'h0C000, 1'b1, E_H12_PM);
        run_vec("vh23", 18'h17000, 1'b0, E_H23);

        // Mid-frame change: rest of this frame keeps the old snapshot.
        check_frame("vmid_old", 1'b0, E_H23, 1'b1, 18'h0DB47);
        check_frame("vmid_new", 1'b0, E_1345_AM, 1'b0, 18'h0);

        // Blink: raise alarm at a frame start, drop it during a blank frame.
        alerm_equal = 1'b1;
        check_frame("blink_f0", 1'b0, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f1", 1'b0, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f2", 1'b0, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f3", 1'b1, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f4", 1'b1, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f5", 1'b0, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f6", 1'b0, E_1345_AM, 1'b0, 18'h0);
        wait_frame();
        alerm_equal = 1'b0;
        check_frame("blink_f7", 1'b1, E_1345_AM, 1'b0, 18'h0);
        check_frame("blink_f8", 1'b0, E_1345_AM, 1'b0, 18'h0);

        // Reset in the middle of a frame.
        for (int k = 0; k < 13; k++) tick();
        reset = 1'b1;
        tick();
        check_blank("midreset", 1'b0);
        tick();
        check_blank("midreset_hold", 1'b0);
        set_inputs(18'h00F00, 1'b0, 1'b0);
        reset_release_check("rerelease");
        check_frame("after_reset", 1'b0, E_MIN60, 1'b0, 18'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
